// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder. It holds one pending word behind a valid/ready handshake
// and shifts it out one bit per clock, with optional idle-zero gaps between words.
module serial_word_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned GAP       = 0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             word_done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH - 1);
  localparam logic [GapW-1:0] GapInit = GapW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             pend_full_q, pend_full_d;
  logic             ready_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             accept;
  logic             reload;

  // ready_q mirrors ~pend_full_q, so a slot freed by a reload is only offered next cycle.
  assign accept = load_valid & ready_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    reload  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend_full_q) reload = 1'b1;
      end
      StShift: begin
        shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (GAP > 0) begin
            state_d = StGap;
            gap_d   = GapInit;
          end else if (pend_full_q) begin
            reload = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          if (pend_full_q) reload = 1'b1;
          else             state_d = StIdle;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (reload) begin
      state_d = StShift;
      shift_d = pend_q;
      cnt_d   = CntInit;
    end

    pend_d      = accept ? data_in : pend_q;
    pend_full_d = pend_full_q;
    if (reload) pend_full_d = 1'b0;
    if (accept) pend_full_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      shift_q     <= '0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b0;
      cnt_q       <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      shift_q     <= shift_d;
      pend_full_q <= pend_full_d;
      ready_q     <= ~pend_full_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
    end
  end

  assign load_ready = ready_q;
  assign bit_valid  = (state_q == StShift);
  assign x_out      = bit_valid & (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
  assign word_done  = bit_valid & (cnt_q == '0);

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder: three instances cover GAP=0 MSB-first,
// GAP=2 MSB-first and GAP=0 LSB-first; one is selected at a time.
module tb_serial_word_feeder;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic [1:0] sel;
  logic [2:0] rdy, xo, bv, wd;
  logic       rdy_s, x_s, bv_s, wd_s;

  int n_cmp;
  int n_fail;

  logic [7:0] words[3];
  int         n_words;
  int         sent;
  logic       rdy_at_drive;

  serial_word_feeder #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) u_dut0 (
    .clock(clk), .reset(rst), .data_in(data), .load_valid(valid && sel == 2'd0),
    .load_ready(rdy[0]), .x_out(xo[0]), .bit_valid(bv[0]), .word_done(wd[0])
  );
  serial_word_feeder #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b1)) u_dut1 (
    .clock(clk), .reset(rst), .data_in(data), .load_valid(valid && sel == 2'd1),
    .load_ready(rdy[1]), .x_out(xo[1]), .bit_valid(bv[1]), .word_done(wd[1])
  );
  serial_word_feeder #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0)) u_dut2 (
    .clock(clk), .reset(rst), .data_in(data), .load_valid(valid && sel == 2'd2),
    .load_ready(rdy[2]), .x_out(xo[2]), .bit_valid(bv[2]), .word_done(wd[2])
  );

  assign rdy_s = rdy[sel];
  assign x_s   = xo[sel];
  assign bv_s  = bv[sel];
  assign wd_s  = wd[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_stream(input int n, input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2);
    words[0]     = w0;
    words[1]     = w1;
    words[2]     = w2;
    n_words      = n;
    sent         = 0;
    rdy_at_drive = 1'b0;
    valid        = 1'b0;
  endtask

  // Called at each falling edge: counts the acceptance at the edge just passed, then drives.
  task automatic feed_step();
    if (valid && rdy_at_drive) sent++;
    if (sent < n_words) begin
      valid        = 1'b1;
      data         = words[sent];
      rdy_at_drive = rdy_s;
    end else begin
      valid        = 1'b0;
      rdy_at_drive = 1'b0;
    end
  endtask

  task automatic test_reset();
    valid = 1'b0;
    data  = '0;
    sel   = 2'd0;
    rst   = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rdy, xo, bv, wd} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 000", {rdy, xo, bv, wd});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rdy, bv} !== 6'b111_000) begin
      n_fail++;
      $display("FAIL reset_release_ready got %b want 111000", {rdy, bv});
    end
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    int k;
    logic ex, ewd, ebv;
    w = 8'hE0;
    @(negedge clk);
    sel = 2'd0;
    start_stream(1, w, 8'h00, 8'h00);
    feed_step();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      k   = c - 2;
      ebv = (k >= 0 && k < 8);
      ex  = ebv ? w[7-k] : 1'b0;
      ewd = (k == 7);
      n_cmp++;
      if ({x_s, bv_s, wd_s} !== {ex, ebv, ewd}) begin
        n_fail++;
        $display("FAIL single_word c=%0d got x/bv/wd=%b want %b", c, {x_s, bv_s, wd_s},
                 {ex, ebv, ewd});
      end
      feed_step();
    end
  endtask

  task automatic test_back_to_back();
    int k;
    logic ex, ewd, ebv;
    @(negedge clk);
    sel = 2'd0;
    start_stream(2, 8'hFF, 8'hFF, 8'h00);
    feed_step();
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      k   = c - 2;
      ebv = (k >= 0 && k < 16);
      ex  = ebv;
      ewd = (k == 7) || (k == 15);
      n_cmp++;
      if ({x_s, bv_s, wd_s} !== {ex, ebv, ewd}) begin
        n_fail++;
        $display("FAIL back_to_back c=%0d got x/bv/wd=%b want %b", c, {x_s, bv_s, wd_s},
                 {ex, ebv, ewd});
      end
      feed_step();
    end
  endtask

  task automatic test_hold_valid();
    logic [7:0] ws[3];
    int k;
    logic ex, ewd, ebv, erdy;
    ws[0] = 8'hA5;
    ws[1] = 8'h3C;
    ws[2] = 8'hC3;
    @(negedge clk);
    sel = 2'd0;
    start_stream(3, ws[0], ws[1], ws[2]);
    feed_step();
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      k    = c - 2;
      ebv  = (k >= 0 && k < 24);
      ex   = ebv ? ws[k/8][7-(k%8)] : 1'b0;
      ewd  = ebv && (k % 8 == 7);
      erdy = (c == 2) || (c == 10) || (c >= 18);
      n_cmp++;
      if ({x_s, bv_s, wd_s, rdy_s} !== {ex, ebv, ewd, erdy}) begin
        n_fail++;
        $display("FAIL hold_valid c=%0d got x/bv/wd/rdy=%b want %b", c,
                 {x_s, bv_s, wd_s, rdy_s}, {ex, ebv, ewd, erdy});
      end
      feed_step();
    end
    n_cmp++;
    if (sent !== 3) begin
      n_fail++;
      $display("FAIL hold_valid_accepted got %0d want 3", sent);
    end
  endtask

  task automatic test_gap();
    logic [7:0] w;
    int k;
    logic ex, ewd, ebv;
    w = 8'h81;
    @(negedge clk);
    sel = 2'd1;
    start_stream(2, w, w, 8'h00);
    feed_step();
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      k   = c - 2;
      ebv = (k >= 0 && k < 8) || (k >= 10 && k < 18);
      ex  = 1'b0;
      if (k >= 0 && k < 8) ex = w[7-k];
      if (k >= 10 && k < 18) ex = w[17-k];
      ewd = (k == 7) || (k == 17);
      n_cmp++;
      if ({x_s, bv_s, wd_s} !== {ex, ebv, ewd}) begin
        n_fail++;
        $display("FAIL gap c=%0d got x/bv/wd=%b want %b", c, {x_s, bv_s, wd_s},
                 {ex, ebv, ewd});
      end
      feed_step();
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    int k;
    logic ex, ewd, ebv;
    w = 8'h07;
    @(negedge clk);
    sel = 2'd2;
    start_stream(1, w, 8'h00, 8'h00);
    feed_step();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      k   = c - 2;
      ebv = (k >= 0 && k < 8);
      ex  = ebv ? w[k] : 1'b0;
      ewd = (k == 7);
      n_cmp++;
      if ({x_s, bv_s, wd_s} !== {ex, ebv, ewd}) begin
        n_fail++;
        $display("FAIL lsb_first c=%0d got x/bv/wd=%b want %b", c, {x_s, bv_s, wd_s},
                 {ex, ebv, ewd});
      end
      feed_step();
    end
  endtask

  task automatic test_reset_mid_word();
    @(negedge clk);
    sel = 2'd0;
    start_stream(1, 8'hF0, 8'h00, 8'h00);
    feed_step();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({x_s, bv_s} !== ((c >= 2) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL rst_mid_pre c=%0d got x/bv=%b want %b", c, {x_s, bv_s},
                 (c >= 2) ? 2'b11 : 2'b00);
      end
      feed_step();
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({x_s, bv_s, wd_s, rdy_s} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid_immediate got x/bv/wd/rdy=%b want 0000", {x_s, bv_s, wd_s, rdy_s});
    end
    @(negedge clk);
    n_cmp++;
    if ({x_s, bv_s, wd_s, rdy_s} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid_held got x/bv/wd/rdy=%b want 0000", {x_s, bv_s, wd_s, rdy_s});
    end
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({x_s, bv_s, wd_s, rdy_s} !== 4'b0001) begin
        n_fail++;
        $display("FAIL rst_mid_after c=%0d got x/bv/wd/rdy=%b want 0001", c,
                 {x_s, bv_s, wd_s, rdy_s});
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_hold_valid();
    test_gap();
    test_lsb_first();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
